// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb blast scheduler and the blast bitmap.
// Pattern codes are also decoded by the blast bitmap, so keep them in sync.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FUSE     = 2'd1,
    BLAST    = 2'd2,
    COOLDOWN = 2'd3
  } bomb_state_t;

  localparam logic [2:0] BLAST_CROSS = 3'd0;
  localparam logic [2:0] BLAST_VERT  = 3'd1;
  localparam logic [2:0] BLAST_HORIZ = 3'd2;

  localparam int TILE_BITS = 5;

  typedef logic [7:0] frame_cnt_t;

  // Unknown pattern codes fall back to the cross pattern.
  function automatic logic [2:0] clamp_pattern(input logic [2:0] p);
    return (p > BLAST_HORIZ) ? BLAST_CROSS : p;
  endfunction

  function automatic logic [10:0] snap_tile(input logic [10:0] v);
    return {v[10:TILE_BITS], {TILE_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/bomb_rr_arbiter.sv
// Two-requester round-robin arbiter; purely combinational, the pointer
// (last_owner) is held by the parent so it survives an abort.
module bomb_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       en,
  output logic [1:0] win,
  output logic       idx
);

  always_comb begin
    win = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   win = 2'b01;
        2'b10:   win = 2'b10;
        2'b11:   win = last_owner ? 2'b01 : 2'b10;
        default: win = 2'b00;
      endcase
    end
  end

  assign idx = win[1];

endmodule

// File: rtl/bomb_blast_scheduler.sv
// Grants one bomb at a time to one of two players and times its fuse, blast
// and cooldown phases in video frames; all outputs come straight from flops.
module bomb_blast_scheduler
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES     = 120,
  parameter int BLAST_FRAMES    = 30,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        abort,
  input  logic [1:0]  req,
  input  logic [10:0] reqX0,
  input  logic [10:0] reqY0,
  input  logic [10:0] reqX1,
  input  logic [10:0] reqY1,
  input  logic [2:0]  pattern0,
  input  logic [2:0]  pattern1,
  output logic [1:0]  grant,
  output logic        owner,
  output logic [10:0] bombX,
  output logic [10:0] bombY,
  output logic        bomb_visible,
  output logic        blast,
  output logic [2:0]  blast_num,
  output logic        busy
);

  localparam frame_cnt_t FUSE_LAST     = frame_cnt_t'(FUSE_FRAMES - 1);
  localparam frame_cnt_t BLAST_LAST    = frame_cnt_t'(BLAST_FRAMES - 1);
  localparam frame_cnt_t COOLDOWN_LAST = frame_cnt_t'(COOLDOWN_FRAMES - 1);

  bomb_state_t state_reg, state_next;
  frame_cnt_t  cnt_reg, cnt_next;
  logic        last_owner_reg, last_owner_next;
  logic [1:0]  grant_next;
  logic        owner_next;
  logic [10:0] bomb_x_next, bomb_y_next;
  logic [2:0]  blast_num_next;

  logic [1:0]  arb_win;
  logic        arb_idx;
  frame_cnt_t  phase_last;
  logic        phase_done;

  bomb_rr_arbiter u_arbiter (
    .req        (req),
    .last_owner (last_owner_reg),
    .en         ((state_reg == IDLE) && !abort),
    .win        (arb_win),
    .idx        (arb_idx)
  );

  always_comb begin
    unique case (state_reg)
      FUSE:     phase_last = FUSE_LAST;
      BLAST:    phase_last = BLAST_LAST;
      COOLDOWN: phase_last = COOLDOWN_LAST;
      default:  phase_last = '0;
    endcase
  end

  assign phase_done = startOfFrame && (cnt_reg == phase_last);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_owner_next = last_owner_reg;
    grant_next      = 2'b00;
    owner_next      = owner;
    bomb_x_next     = bombX;
    bomb_y_next     = bombY;
    blast_num_next  = blast_num;

    unique case (state_reg)
      IDLE: begin
        if (arb_win != 2'b00) begin
          state_next      = FUSE;
          cnt_next        = '0;
          grant_next      = arb_win;
          owner_next      = arb_idx;
          last_owner_next = arb_idx;
          bomb_x_next     = snap_tile(arb_idx ? reqX1 : reqX0);
          bomb_y_next     = snap_tile(arb_idx ? reqY1 : reqY0);
          blast_num_next  = clamp_pattern(arb_idx ? pattern1 : pattern0);
        end
      end
      FUSE, BLAST, COOLDOWN: begin
        if (phase_done) begin
          cnt_next = '0;
          if (state_reg == FUSE)
            state_next = BLAST;
          else if (state_reg == BLAST && COOLDOWN_FRAMES != 0)
            state_next = COOLDOWN;
          else
            state_next = IDLE;
        end else if (startOfFrame) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort overrides everything except the round-robin pointer.
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
      grant_next = 2'b00;
    end

    if (state_next == IDLE) begin
      owner_next     = 1'b0;
      bomb_x_next    = '0;
      bomb_y_next    = '0;
      blast_num_next = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_owner_reg <= 1'b1;
      grant          <= 2'b00;
      owner          <= 1'b0;
      bombX          <= '0;
      bombY          <= '0;
      blast_num      <= '0;
      bomb_visible   <= 1'b0;
      blast          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_owner_reg <= last_owner_next;
      grant          <= grant_next;
      owner          <= owner_next;
      bombX          <= bomb_x_next;
      bombY          <= bomb_y_next;
      blast_num      <= blast_num_next;
      bomb_visible   <= (state_next == FUSE);
      blast          <= (state_next == BLAST);
      busy           <= (state_next != IDLE);
    end
  end

endmodule
